// File: rtl/lfsr_pkg.sv
// Shared constants, state encoding and next-state function for the 8-bit
// Fibonacci LFSR and its arbiter.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hB8;
  // Feedback taps at bits 7, 5, 4 and 3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic {
    ST_IDLE,
    ST_SERVE
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] n);
    return {^(n & LFSR_TAPS), n[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 8-bit LFSR state register with load and step controls; load beats step,
// and a zero load is replaced by the default seed to avoid lock-up.
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (load) begin
      state <= (load_val == '0) ? LFSR_SEED : load_val;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one LFSR: each grant delivers one fresh value,
// with seed loading and an optional idle free-run tick.
module lfsr_arbiter
  import lfsr_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [NREQ-1:0]   gnt,
  output logic              rnd_valid,
  output logic [LFSR_W-1:0] rnd_out
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);
  localparam logic [31:0] TICK_LAST = 32'((TICK_DIV > 0) ? TICK_DIV - 1 : 0);

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  pick;
  logic              found;
  logic [31:0]       tick_cnt;
  logic              tick_hit;
  logic              idle;
  logic              lfsr_step;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_q;

  // NOTE: combinational logic uses blocking assignments and gives every
  // output a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    logic [PTR_W-1:0] idx;
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
    end
  end

  assign idle      = (state == ST_IDLE);
  assign tick_hit  = (TICK_DIV != 0) && (tick_cnt == TICK_LAST);
  assign lfsr_load = idle && seed_load;
  assign lfsr_step = (state == ST_SERVE) || (idle && !seed_load && !(|req) && tick_hit);

  lfsr_core u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (seed),
    .state    (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      winner    <= '0;
      tick_cnt  <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A seed load only touches the LFSR core; everything here holds.
          if (!seed_load) begin
            if (|req) begin
              winner    <= pick;
              gnt       <= NREQ'(1) << pick;
              rnd_valid <= 1'b1;
              rnd_out   <= lfsr_q;
              state     <= ST_SERVE;
            end else if (TICK_DIV != 0) begin
              tick_cnt <= tick_hit ? '0 : tick_cnt + 32'd1;
            end
          end
        end
        ST_SERVE: begin
          gnt       <= '0;
          rnd_valid <= 1'b0;
          ptr       <= (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a transaction-level reference model, for TICK_DIV=0 and TICK_DIV=3.
module tb_lfsr_arbiter;

  localparam int NREQ = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       seed_load;
  logic [7:0] seed;
  logic [3:0] gnt0, gnt1;
  logic       valid0, valid1;
  logic [7:0] rout0, rout1;

  int total;
  int bad;

  typedef struct {
    logic [7:0] lfsr;
    int         ptr;
    int         tick;
    bit         busy;
    int         win;
    logic [3:0] gnt;
    logic       valid;
    logic [7:0] rout;
    int         div;
  } model_t;

  model_t m[2];

  lfsr_arbiter #(.NREQ(NREQ), .TICK_DIV(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed(seed),
    .gnt(gnt0), .rnd_valid(valid0), .rnd_out(rout0)
  );

  lfsr_arbiter #(.NREQ(NREQ), .TICK_DIV(3)) dut1 (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed(seed),
    .gnt(gnt1), .rnd_valid(valid1), .rnd_out(rout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feedback is the parity of the tapped bits x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] ref_step(input logic [7:0] n);
    int fb;
    fb = $countones(n & 8'hB8) % 2;
    return 8'((n >> 1) | (fb << 7));
  endfunction

  function automatic model_t model_step(input model_t s, input logic r, input logic [3:0] rq,
                                        input logic sl, input logic [7:0] sd);
    model_t o;
    int w;
    o = s;
    w = -1;
    if (r) begin
      o.lfsr = 8'hB8; o.ptr = 0; o.tick = 0; o.busy = 0; o.win = 0;
      o.gnt = 4'b0; o.valid = 1'b0; o.rout = 8'h00;
    end else if (s.busy) begin
      o.gnt = 4'b0; o.valid = 1'b0;
      o.lfsr = ref_step(s.lfsr);
      o.ptr = (s.win + 1) % NREQ;
      o.busy = 0;
    end else if (sl) begin
      o.lfsr = (sd == 8'h00) ? 8'hB8 : sd;
    end else if (rq != 4'b0) begin
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && rq[(s.ptr + k) % NREQ]) w = (s.ptr + k) % NREQ;
      o.win = w;
      o.gnt = 4'(1 << w);
      o.valid = 1'b1;
      o.rout = s.lfsr;
      o.busy = 1;
    end else if (s.div != 0) begin
      if (s.tick == s.div - 1) begin
        o.lfsr = ref_step(s.lfsr);
        o.tick = 0;
      end else begin
        o.tick = s.tick + 1;
      end
    end
    return o;
  endfunction

  task automatic drive(input logic r, input logic [3:0] rq, input logic sl, input logic [7:0] sd);
    rst = r; req = rq; seed_load = sl; seed = sd;
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = model_step(m[i], r, rq, sl, sd);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0 || valid0 !== 1'b0 || rout0 !== 8'h00) begin
      bad++;
      $display("FAIL reset0: got gnt=%b valid=%b rnd=%h, expected 0000/0/00", gnt0, valid0, rout0);
    end
    total++;
    if (gnt1 !== 4'b0 || valid1 !== 1'b0 || rout1 !== 8'h00) begin
      bad++;
      $display("FAIL reset1: got gnt=%b valid=%b rnd=%h, expected 0000/0/00", gnt1, valid1, rout1);
    end
  endtask

  task automatic test_single_pulse();
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    drive(1'b0, 4'b0001, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0001 || valid0 !== 1'b1 || rout0 !== 8'hB8) begin
      bad++;
      $display("FAIL pulse1: got gnt=%b valid=%b rnd=%h, expected 0001/1/b8", gnt0, valid0, rout0);
    end
    drive(1'b0, 4'b0, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0 || valid0 !== 1'b0 || rout0 !== 8'hB8) begin
      bad++;
      $display("FAIL pulse_hold: got gnt=%b valid=%b rnd=%h, expected 0000/0/b8", gnt0, valid0, rout0);
    end
    drive(1'b0, 4'b0001, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0001 || rout0 !== 8'h5C) begin
      bad++;
      $display("FAIL pulse2: got gnt=%b rnd=%h, expected 0001/5c", gnt0, rout0);
    end
    drive(1'b0, 4'b0, 1'b0, 8'h00);
  endtask

  task automatic test_all_held();
    logic [7:0] exp_rnd [5];
    logic [3:0] exp_gnt;
    exp_rnd = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'h8B};
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'b1111, 1'b0, 8'h00);
      exp_gnt = (k % 2 == 0) ? 4'(1 << ((k / 2) % 4)) : 4'b0;
      total++;
      if (gnt0 !== exp_gnt || (k % 2 == 0 && rout0 !== exp_rnd[k / 2])) begin
        bad++;
        $display("FAIL all_held[%0d]: got gnt=%b rnd=%h, expected gnt=%b rnd=%h",
                 k, gnt0, rout0, exp_gnt, exp_rnd[k / 2]);
      end
    end
    drive(1'b0, 4'b0, 1'b0, 8'h00);
  endtask

  task automatic test_seed();
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    drive(1'b0, 4'b0, 1'b1, 8'h00);
    drive(1'b0, 4'b0001, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0001 || rout0 !== 8'hB8) begin
      bad++;
      $display("FAIL seed_zero: got gnt=%b rnd=%h, expected 0001/b8", gnt0, rout0);
    end
    drive(1'b0, 4'b0, 1'b0, 8'h00);
    drive(1'b0, 4'b0100, 1'b1, 8'h17);
    total++;
    if (gnt0 !== 4'b0 || valid0 !== 1'b0) begin
      bad++;
      $display("FAIL seed_nogrant: got gnt=%b valid=%b, expected 0000/0", gnt0, valid0);
    end
    drive(1'b0, 4'b0100, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0100 || valid0 !== 1'b1 || rout0 !== 8'h17) begin
      bad++;
      $display("FAIL seed_17: got gnt=%b valid=%b rnd=%h, expected 0100/1/17", gnt0, valid0, rout0);
    end
    drive(1'b0, 4'b0, 1'b0, 8'h00);
  endtask

  task automatic test_tick();
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    repeat (6) drive(1'b0, 4'b0, 1'b0, 8'h00);
    drive(1'b0, 4'b0010, 1'b0, 8'h00);
    total++;
    if (gnt1 !== 4'b0010 || rout1 !== 8'h2E) begin
      bad++;
      $display("FAIL tick3: got gnt=%b rnd=%h, expected 0010/2e", gnt1, rout1);
    end
    total++;
    if (gnt0 !== 4'b0010 || rout0 !== 8'hB8) begin
      bad++;
      $display("FAIL tick0: got gnt=%b rnd=%h, expected 0010/b8", gnt0, rout0);
    end
    drive(1'b0, 4'b0, 1'b0, 8'h00);
  endtask

  task automatic test_ptr2();
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    drive(1'b0, 4'b0010, 1'b0, 8'h00);
    drive(1'b0, 4'b0, 1'b0, 8'h00);
    drive(1'b0, 4'b1010, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b1000 || rout0 !== 8'h5C) begin
      bad++;
      $display("FAIL ptr2_first: got gnt=%b rnd=%h, expected 1000/5c", gnt0, rout0);
    end
    drive(1'b0, 4'b1010, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0 || valid0 !== 1'b0) begin
      bad++;
      $display("FAIL ptr2_gap: got gnt=%b valid=%b, expected 0000/0", gnt0, valid0);
    end
    drive(1'b0, 4'b1010, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0010 || rout0 !== 8'h2E) begin
      bad++;
      $display("FAIL ptr2_second: got gnt=%b rnd=%h, expected 0010/2e", gnt0, rout0);
    end
    drive(1'b0, 4'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_serve();
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    drive(1'b0, 4'b0001, 1'b0, 8'h00);
    drive(1'b1, 4'b0001, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0 || valid0 !== 1'b0 || rout0 !== 8'h00) begin
      bad++;
      $display("FAIL rst_serve: got gnt=%b valid=%b rnd=%h, expected 0000/0/00", gnt0, valid0, rout0);
    end
    drive(1'b0, 4'b0001, 1'b0, 8'h00);
    total++;
    if (gnt0 !== 4'b0001 || rout0 !== 8'hB8) begin
      bad++;
      $display("FAIL rst_regrant: got gnt=%b rnd=%h, expected 0001/b8", gnt0, rout0);
    end
    drive(1'b0, 4'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic       r, sl;
    logic [3:0] rq, prev0;
    logic [7:0] sd;
    drive(1'b1, 4'b0, 1'b0, 8'h00);
    prev0 = 4'b0;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      rq = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
      sl = ($urandom_range(0, 7) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      drive(r, rq, sl, sd);
      total++;
      if (gnt0 !== m[0].gnt || valid0 !== m[0].valid || rout0 !== m[0].rout) begin
        bad++;
        $display("FAIL rand0[%0d]: got gnt=%b valid=%b rnd=%h, expected gnt=%b valid=%b rnd=%h",
                 n, gnt0, valid0, rout0, m[0].gnt, m[0].valid, m[0].rout);
      end
      total++;
      if (gnt1 !== m[1].gnt || valid1 !== m[1].valid || rout1 !== m[1].rout) begin
        bad++;
        $display("FAIL rand1[%0d]: got gnt=%b valid=%b rnd=%h, expected gnt=%b valid=%b rnd=%h",
                 n, gnt1, valid1, rout1, m[1].gnt, m[1].valid, m[1].rout);
      end
      total++;
      if ($countones(gnt0) > 1 || (gnt0 != 4'b0 && prev0 != 4'b0) || (valid0 !== (gnt0 != 4'b0))) begin
        bad++;
        $display("FAIL onehot[%0d]: got gnt=%b prev=%b valid=%b, expected one-hot, isolated, valid==|gnt",
                 n, gnt0, prev0, valid0);
      end
      prev0 = gnt0;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1; req = 4'b0; seed_load = 1'b0; seed = 8'h00;
    m[0] = '{lfsr: 8'hB8, ptr: 0, tick: 0, busy: 0, win: 0, gnt: 4'b0, valid: 1'b0, rout: 8'h00, div: 0};
    m[1] = '{lfsr: 8'hB8, ptr: 0, tick: 0, busy: 0, win: 0, gnt: 4'b0, valid: 1'b0, rout: 8'h00, div: 3};
    test_reset();
    test_single_pulse();
    test_all_held();
    test_seed();
    test_tick();
    test_ptr2();
    test_reset_mid_serve();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
